// File: rtl/tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, status-word
// marker and field placement helpers.
package tx_scheduler_pkg;

  localparam int DEFAULT_DATA_WIDTH_BYTES = 18;
  localparam int MARKER_WIDTH             = 8;
  localparam int SEQ_WIDTH                = 32;
  localparam logic [MARKER_WIDTH-1:0] STATUS_MARKER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    READ_FIFO,
    LOAD_REC,
    LOAD_STATUS,
    SEND,
    WAIT_DONE
  } state_t;

  // Status word, MSB first: marker | drop count | sequence number | zero fill.
  function automatic int drop_field_lsb(input int word_width, input int drop_width);
    return word_width - MARKER_WIDTH - drop_width;
  endfunction

  function automatic int seq_field_lsb(input int word_width, input int drop_width);
    return word_width - MARKER_WIDTH - drop_width - SEQ_WIDTH;
  endfunction

endpackage

// File: rtl/tx_scheduler_status_timer.sv
// Free-running status period timer (advances only while enabled) with a
// single-entry pending flag that the scheduler clears when it serves the request.
module tx_scheduler_status_timer #(
  parameter int STATUS_PERIOD = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic pending
);

  localparam int TW = $clog2(STATUS_PERIOD);
  localparam logic [TW-1:0] LAST = TW'(STATUS_PERIOD - 1);

  logic [TW-1:0] timer;
  logic          expire;

  assign expire = enable && (timer == LAST);

  // NOTE: state registers use <= so every flop samples pre-edge values;
  // blocking assignments here would create simulation order races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer   <= '0;
      pending <= 1'b0;
    end else begin
      if (enable) timer <= expire ? '0 : timer + 1'b1;
      // A clear wins over a coincident expiry: that expiry lands on an
      // already pending request and is absorbed, like any other.
      pending <= clear ? 1'b0 : (pending | expire);
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Shares the UART serializer between the tag-record FIFO and a periodic status
// word, and counts records lost to a full FIFO.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH_BYTES = DEFAULT_DATA_WIDTH_BYTES,
  parameter int STATUS_PERIOD    = 50000000,
  parameter int MAX_BURST        = 8,
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          record_rdy,
  input  logic                          rec_buf_full,
  input  logic                          rec_buf_empty,
  input  logic [8*DATA_WIDTH_BYTES-1:0] rec_buf_out,
  output logic                          rec_buf_rdnext,
  output logic [8*DATA_WIDTH_BYTES-1:0] uart_data,
  output logic                          uart_send,
  input  logic                          uart_done,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count,
  output logic                          status_sent,
  output logic                          busy
);

  localparam int W        = 8 * DATA_WIDTH_BYTES;
  localparam int DROP_LSB = drop_field_lsb(W, DROP_CNT_WIDTH);
  localparam int SEQ_LSB  = seq_field_lsb(W, DROP_CNT_WIDTH);
  localparam int BW       = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_BURST);

  state_t                 state;
  logic [BW-1:0]          burst_cnt;
  logic [SEQ_WIDTH-1:0]   seq_num;
  logic                   done_armed;
  logic                   status_pending;
  logic                   drop_evt;
  logic [W-1:0]           status_word;

  tx_scheduler_status_timer #(.STATUS_PERIOD(STATUS_PERIOD)) u_status_timer (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .clear   (state == LOAD_STATUS),
    .pending (status_pending)
  );

  assign drop_evt = record_rdy && rec_buf_full;

  // NOTE: assign a default before any partial field write so no bit of the
  // word is left holding its old value, which would infer a latch.
  always_comb begin
    status_word = '0;
    status_word[W-1 -: MARKER_WIDTH]          = STATUS_MARKER;
    status_word[DROP_LSB +: DROP_CNT_WIDTH]   = drop_count;
    status_word[SEQ_LSB +: SEQ_WIDTH]         = seq_num;
  end

  // The status word captures the pre-clear count; a drop arriving in that
  // same cycle becomes the first count of the next interval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (state == LOAD_STATUS) begin
      drop_count <= DROP_CNT_WIDTH'(drop_evt);
    end else if (drop_evt && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rec_buf_rdnext <= 1'b0;
      uart_data      <= '0;
      uart_send      <= 1'b0;
      status_sent    <= 1'b0;
      busy           <= 1'b0;
      burst_cnt      <= '0;
      seq_num        <= '0;
      done_armed     <= 1'b0;
    end else begin
      rec_buf_rdnext <= 1'b0;
      uart_send      <= 1'b0;
      status_sent    <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            if (status_pending && (rec_buf_empty || burst_cnt == BURST_LIMIT)) begin
              state <= LOAD_STATUS;
              busy  <= 1'b1;
            end else if (!rec_buf_empty) begin
              state          <= READ_FIFO;
              rec_buf_rdnext <= 1'b1;
              busy           <= 1'b1;
            end
          end
        end
        READ_FIFO: state <= LOAD_REC;
        LOAD_REC: begin
          uart_data <= rec_buf_out;
          if (burst_cnt != BURST_LIMIT) burst_cnt <= burst_cnt + 1'b1;
          uart_send <= 1'b1;
          state     <= SEND;
        end
        LOAD_STATUS: begin
          uart_data   <= status_word;
          burst_cnt   <= '0;
          seq_num     <= seq_num + 1'b1;
          uart_send   <= 1'b1;
          status_sent <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          done_armed <= 1'b0;
          state      <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // The first cycle here may still see the previous word's done level.
          if (!done_armed) begin
            done_armed <= 1'b1;
          end else if (uart_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: FIFO and UART models plus a scoreboard of
// expected UART words in send order.
module tb_tx_scheduler;

  localparam int W = 144;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic          record_rdy = 1'b0;
  logic          rec_buf_full = 1'b0;
  wire           rec_buf_empty;
  logic [W-1:0]  rec_buf_out = '0;
  logic          rec_buf_rdnext;
  logic [W-1:0]  uart_data;
  logic          uart_send;
  wire           uart_done;
  logic [15:0]   drop_count;
  logic          status_sent;
  logic          busy;

  int n_asserts = 0;
  int n_fail    = 0;

  // Record FIFO model: written by the stimulus, read by the model process.
  logic [W-1:0] fifo_mem [0:63];
  int           fifo_wr = 0;
  int           rd_ptr  = 0;
  // Scoreboard ring of expected UART words.
  logic [W-1:0] exp_mem [0:63];
  int           exp_wr = 0;
  int           exp_rd = 0;

  int   rd_count   = 0;
  int   send_count = 0;
  int   done_cnt   = 0;
  logic done_hold  = 1'b0;

  assign rec_buf_empty = (rd_ptr == fifo_wr);
  assign uart_done     = done_hold | (done_cnt == 1);

  always #5 clk = ~clk;

  tx_scheduler #(
    .DATA_WIDTH_BYTES (18),
    .STATUS_PERIOD    (20),
    .MAX_BURST        (8),
    .DROP_CNT_WIDTH   (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .record_rdy     (record_rdy),
    .rec_buf_full   (rec_buf_full),
    .rec_buf_empty  (rec_buf_empty),
    .rec_buf_out    (rec_buf_out),
    .rec_buf_rdnext (rec_buf_rdnext),
    .uart_data      (uart_data),
    .uart_send      (uart_send),
    .uart_done      (uart_done),
    .drop_count     (drop_count),
    .status_sent    (status_sent),
    .busy           (busy)
  );

  // Data appears the cycle after a read request.
  always @(posedge clk) begin
    if (rec_buf_rdnext && (rd_ptr != fifo_wr)) begin
      rec_buf_out <= fifo_mem[rd_ptr % 64];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  // UART returns a one-cycle done pulse ten cycles after each trigger.
  always @(posedge clk) begin
    if (uart_send)         done_cnt <= 10;
    else if (done_cnt > 0) done_cnt <= done_cnt - 1;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_status(input logic [15:0] drops, input logic [31:0] seq);
    logic [W-1:0] w;
    w = '0;
    w[143:136] = 8'hA5;
    w[135:120] = drops;
    w[119:88]  = seq;
    return w;
  endfunction

  task automatic push_exp(input logic [W-1:0] w);
    exp_mem[exp_wr % 64] = w;
    exp_wr++;
  endtask

  task automatic push_fifo(input logic [W-1:0] r);
    fifo_mem[fifo_wr % 64] = r;
    fifo_wr++;
  endtask

  task automatic push_rec();
    logic [159:0] t;
    logic [W-1:0] r;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    r = t[W-1:0];
    r[W-1] = 1'b0;
    push_fifo(r);
    push_exp(r);
  endtask

  // One clock, sampled at the falling edge, scoring every UART trigger.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (uart_send) begin
      send_count++;
      check("send_expected", (exp_wr - exp_rd) > 0, 1'b1);
      if (exp_wr > exp_rd) begin
        e = exp_mem[exp_rd % 64];
        exp_rd++;
        check("uart_data", uart_data, e);
        check("status_sent", status_sent, e[143:136] == 8'hA5);
      end
    end
    if (rec_buf_rdnext) begin
      rd_count++;
      check("rd_not_empty", rec_buf_empty, 1'b0);
    end
  endtask

  task automatic wait_sb(input int limit);
    int k;
    k = 0;
    while ((exp_rd != exp_wr) && (k < limit)) begin
      tick();
      k++;
    end
    check("sb_drained", exp_wr - exp_rd, 0);
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b0;
    done_hold = 1'b0;
    fifo_wr   = rd_ptr;
    exp_rd    = exp_wr;
    repeat (3) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int k, s0, r0;

    // Reset state.
    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_send", uart_send, 1'b0);
    check("rst_data", uart_data, '0);
    check("rst_rdnext", rec_buf_rdnext, 1'b0);
    check("rst_drops", drop_count, 16'h0);
    check("rst_status", status_sent, 1'b0);

    // Three preloaded records, then enable falls during the last transfer.
    do_reset();
    repeat (3) push_rec();
    s0 = send_count;
    r0 = rd_count;
    enable = 1'b1;
    k = 0;
    while ((send_count < s0 + 3) && (k < 100)) begin tick(); k++; end
    enable = 1'b0;
    check("rec_sends", send_count - s0, 3);
    repeat (20) tick();
    check("rec_reads", rd_count - r0, 3);
    check("rec_idle_busy", busy, 1'b0);
    check("rec_sb_empty", exp_wr - exp_rd, 0);

    // Status words with an empty FIFO: latency and sequence numbering.
    do_reset();
    push_exp(mk_status(16'd0, 32'd0));
    push_exp(mk_status(16'd0, 32'd1));
    enable = 1'b1;
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (status_sent) break;
    end
    check("status_latency", k, 22);
    wait_sb(100);
    enable = 1'b0;

    // Drops are counted, reported in the next status word, then cleared.
    for (int i = 0; i < 5; i++) begin
      rec_buf_full = 1'b1;
      record_rdy   = 1'b1;
      tick();
      record_rdy = 1'b0;
      tick();
    end
    rec_buf_full = 1'b0;
    check("drop_count5", drop_count, 16'd5);
    push_exp(mk_status(16'd5, 32'd2));
    enable = 1'b1;
    wait_sb(100);
    check("drop_cleared", drop_count, 16'd0);
    enable = 1'b0;

    // Saturation of the drop counter.
    rec_buf_full = 1'b1;
    record_rdy   = 1'b1;
    repeat (70000) tick();
    record_rdy   = 1'b0;
    rec_buf_full = 1'b0;
    tick();
    check("drop_saturate", drop_count, 16'hFFFF);

    // Continuous FIFO: eight records, status, remaining records, status.
    do_reset();
    repeat (8) push_rec();
    push_exp(mk_status(16'd0, 32'd0));
    repeat (4) push_rec();
    push_exp(mk_status(16'd0, 32'd1));
    enable = 1'b1;
    wait_sb(400);
    enable = 1'b0;
    repeat (20) tick();

    // A done level already high must be ignored in the first WAIT_DONE cycle.
    do_reset();
    done_hold = 1'b1;
    push_rec();
    s0 = send_count;
    enable = 1'b1;
    k = 0;
    while ((send_count < s0 + 1) && (k < 50)) begin tick(); k++; end
    enable = 1'b0;
    tick();
    check("wait_done_c1_busy", busy, 1'b1);
    tick();
    check("wait_done_c2_busy", busy, 1'b1);
    tick();
    check("wait_done_exit_busy", busy, 1'b0);
    done_hold = 1'b0;

    // Asynchronous reset while waiting for done.
    do_reset();
    push_rec();
    push_fifo(W'(144'h1234_5678));
    s0 = send_count;
    enable = 1'b1;
    k = 0;
    while ((send_count < s0 + 1) && (k < 50)) begin tick(); k++; end
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_data", uart_data, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_send", uart_send, 1'b0);
    check("arst_rdnext", rec_buf_rdnext, 1'b0);
    check("arst_status", status_sent, 1'b0);
    check("arst_drops", drop_count, 16'h0);
    enable = 1'b0;
    r0 = rd_count;
    tick();
    reset = 1'b1;
    repeat (20) tick();
    check("arst_no_reread", rd_count - r0, 0);
    check("arst_idle_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
